// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, A10 index and refresh FSM state type.
// Used by the init, refresh, write and read blocks of the SDRAM controller.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam int unsigned A10_IDX = 10;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StTrp,
    StAref,
    StTrfc,
    StDone
  } aref_state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval ticker plus saturating postponed-refresh debt counter.
// Produces the current debt and the urgent flag for the refresh FSM.
module sdram_ref_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 1499,
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned URGENT_TH    = 6,
  parameter int unsigned DebtW        = $clog2(MAX_DEBT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_done_i,
  input  logic             aref_i,
  output logic [DebtW-1:0] debt_o,
  output logic             urgent_o
);

  localparam int unsigned TickW = (REF_INTERVAL > 0) ? $clog2(REF_INTERVAL + 1) : 1;

  logic [TickW-1:0] ticker_q, ticker_d;
  logic [DebtW-1:0] debt_q, debt_d;
  logic             tick;

  assign tick = init_done_i && (ticker_q == TickW'(REF_INTERVAL));

  always_comb begin
    ticker_d = '0;
    if (init_done_i && !tick) begin
      ticker_d = ticker_q + 1'b1;
    end

    // A tick and an AREF in the same cycle cancel out.
    debt_d = debt_q;
    if (tick && !aref_i) begin
      if (debt_q != DebtW'(MAX_DEBT)) begin
        debt_d = debt_q + 1'b1;
      end
    end else if (!tick && aref_i) begin
      if (debt_q != '0) begin
        debt_d = debt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ticker_q <= '0;
      debt_q   <= '0;
    end else begin
      ticker_q <= ticker_d;
      debt_q   <= debt_d;
    end
  end

  assign debt_o   = debt_q;
  assign urgent_o = (debt_q >= DebtW'(URGENT_TH));

endmodule

// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh engine: PRE-all then a burst of AREFs per arbiter grant.
// Optional statistics outputs are enabled by defining SDRAM_AREF_STATS_EN.
module sdram_aref_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 1499,
  parameter int unsigned TRP_CYC      = 2,
  parameter int unsigned TRFC_CYC     = 7,
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned URGENT_TH    = 6,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned ADDR_W       = 13
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              flag_init_end,
  input  logic              ref_en,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic              flag_ref_end,
  output logic [3:0]        aref_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              ref_busy
`ifdef SDRAM_AREF_STATS_EN
  ,
  output logic [15:0]                    ref_total,
  output logic [$clog2(MAX_DEBT+1)-1:0]  debt_peak
`endif
);

  localparam int unsigned DebtW  = $clog2(MAX_DEBT + 1);
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned WaitMx = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int unsigned WaitW  = $clog2(WaitMx + 1);
  localparam logic [ADDR_W-1:0] RefAddr = ADDR_W'(1) << A10_IDX;

  aref_state_t       state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              req_q, req_d;
  logic              urgent_q, urgent_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;
  logic [DebtW-1:0]  debt;
  logic              urgent;
  logic              accept;

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_DEBT     (MAX_DEBT),
    .URGENT_TH    (URGENT_TH),
    .DebtW        (DebtW)
  ) u_timer (
    .clk_i       (sclk),
    .rst_ni      (s_rst_n),
    .init_done_i (flag_init_end),
    .aref_i      (state_q == StAref),
    .debt_o      (debt),
    .urgent_o    (urgent)
  );

  assign accept = ref_en && (state_q == StIdle) && (debt != '0);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StPre;
          burst_d = (debt > DebtW'(MAX_BURST)) ? BurstW'(MAX_BURST) : BurstW'(debt);
        end
      end
      StPre: begin
        state_d = StTrp;
        wait_d  = WaitW'(TRP_CYC - 1);
      end
      StTrp: begin
        if (wait_q == '0) state_d = StAref;
        else              wait_d  = wait_q - 1'b1;
      end
      StAref: begin
        state_d = StTrfc;
        wait_d  = WaitW'(TRFC_CYC - 1);
        burst_d = burst_q - 1'b1;
      end
      StTrfc: begin
        if (wait_q == '0) state_d = (burst_q != '0) ? StAref : StDone;
        else              wait_d  = wait_q - 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    cmd_d = CMD_NOP;
    if (state_d == StPre)  cmd_d = CMD_PRE;
    if (state_d == StAref) cmd_d = CMD_AREF;
    req_d    = (debt != '0) && (state_d == StIdle);
    urgent_d = urgent;
    end_d    = (state_d == StDone);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      burst_q  <= '0;
      cmd_q    <= CMD_NOP;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      cmd_q    <= cmd_d;
      req_q    <= req_d;
      urgent_q <= urgent_d;
      end_q    <= end_d;
      busy_q   <= busy_d;
    end
  end

  assign ref_req      = req_q;
  assign ref_urgent   = urgent_q;
  assign flag_ref_end = end_q;
  assign aref_cmd     = cmd_q;
  assign ref_busy     = busy_q;
  assign sdram_addr   = RefAddr;

`ifdef SDRAM_AREF_STATS_EN
  logic [15:0]      total_q, total_d;
  logic [DebtW-1:0] peak_q, peak_d;

  always_comb begin
    total_d = total_q;
    peak_d  = peak_q;
    if ((state_q == StAref) && (total_q != 16'hFFFF)) total_d = total_q + 1'b1;
    if (debt > peak_q) peak_d = debt;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      total_q <= '0;
      peak_q  <= '0;
    end else begin
      total_q <= total_d;
      peak_q  <= peak_d;
    end
  end

  assign ref_total = total_q;
  assign debt_peak = peak_q;
`endif

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Scoreboard bench for sdram_aref_ctrl: a cycle-level reference model schedules
// the expected PRE/AREF/end events; a monitor pops and compares them.
module tb_sdram_aref_ctrl;

  localparam int RI   = 1499;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int MAXD = 8;
  localparam int UT   = 6;
  localparam int MB   = 4;
  localparam int AW   = 13;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic          sclk = 1'b0;
  logic          s_rst_n = 1'b0;
  logic          flag_init_end = 1'b0;
  logic          ref_en = 1'b0;
  logic          ref_req, ref_urgent, flag_ref_end, ref_busy;
  logic [3:0]    aref_cmd;
  logic [AW-1:0] sdram_addr;
`ifdef SDRAM_AREF_STATS_EN
  logic [15:0]   ref_total;
  logic [3:0]    debt_peak;
`endif

  always #5 sclk = ~sclk;

  sdram_aref_ctrl dut (
    .sclk          (sclk),
    .s_rst_n       (s_rst_n),
    .flag_init_end (flag_init_end),
    .ref_en        (ref_en),
    .ref_req       (ref_req),
    .ref_urgent    (ref_urgent),
    .flag_ref_end  (flag_ref_end),
    .aref_cmd      (aref_cmd),
    .sdram_addr    (sdram_addr),
    .ref_busy      (ref_busy)
`ifdef SDRAM_AREF_STATS_EN
    ,
    .ref_total     (ref_total),
    .debt_peak     (debt_peak)
`endif
  );

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic       fin;
  } ev_t;

  ev_t exp_q[$];
  int  aref_sched[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model state (values for the current cycle).
  int   cyc = 0;
  int   m_ticker = 0;
  int   m_debt = 0;
  int   m_busy_last = -1;
  logic e_req = 1'b0;
  logic e_urg = 1'b0;
  logic e_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: refresh rules evaluated once per clock edge.
  int   c, tick, aref_now, old_debt, b, len, a;
  ev_t  ev;
  initial begin
    forever begin
      @(posedge sclk or negedge s_rst_n);
      if (!s_rst_n) begin
        cyc = 0; m_ticker = 0; m_debt = 0; m_busy_last = -1;
        e_req = 1'b0; e_urg = 1'b0; e_busy = 1'b0;
        exp_q.delete();
        aref_sched.delete();
      end else begin
        c = cyc;
        tick = (flag_init_end && m_ticker == RI) ? 1 : 0;
        m_ticker = flag_init_end ? ((tick != 0) ? 0 : m_ticker + 1) : 0;
        aref_now = 0;
        if (aref_sched.size() > 0 && aref_sched[0] == c) begin
          aref_now = 1;
          void'(aref_sched.pop_front());
        end
        old_debt = m_debt;
        if (ref_en && c > m_busy_last && old_debt != 0) begin
          b = (old_debt < MB) ? old_debt : MB;
          ev.cyc = c + 1; ev.cmd = PRE; ev.fin = 1'b0;
          exp_q.push_back(ev);
          for (int k = 0; k < b; k++) begin
            a = c + 2 + TRP + k * (1 + TRFC);
            ev.cyc = a; ev.cmd = AREF; ev.fin = 1'b0;
            exp_q.push_back(ev);
            aref_sched.push_back(a);
          end
          len = 2 + TRP + b * (1 + TRFC);
          ev.cyc = c + len; ev.cmd = NOP; ev.fin = 1'b1;
          exp_q.push_back(ev);
          m_busy_last = c + len;
        end
        m_debt = old_debt + tick - aref_now;
        if (m_debt > MAXD) m_debt = MAXD;
        e_req  = (old_debt != 0) && (c + 1 > m_busy_last);
        e_urg  = (old_debt >= UT);
        e_busy = (c + 1 <= m_busy_last);
        cyc = c + 1;
      end
    end
  end

  // Monitor: level checks every cycle, event checks whenever a command/end shows.
  ev_t mev;
  initial begin
    forever begin
      @(negedge sclk);
      if (s_rst_n) begin
        chk("ref_req", 32'(ref_req), 32'(e_req));
        chk("ref_urgent", 32'(ref_urgent), 32'(e_urg));
        chk("ref_busy", 32'(ref_busy), 32'(e_busy));
        chk("sdram_addr", 32'(sdram_addr), 32'h400);
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          mev = exp_q.pop_front();
          chk("missed_event_cycle", 32'(cyc), 32'(mev.cyc));
        end
        if (aref_cmd != NOP || flag_ref_end) begin
          if (exp_q.size() == 0) begin
            chk("spurious_event", {27'd0, flag_ref_end, aref_cmd}, {27'd0, 1'b0, NOP});
          end else begin
            mev = exp_q.pop_front();
            chk("event_cycle", 32'(cyc), 32'(mev.cyc));
            chk("aref_cmd", 32'(aref_cmd), 32'(mev.cmd));
            chk("flag_ref_end", 32'(flag_ref_end), 32'(mev.fin));
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic grant();
    @(negedge sclk);
    ref_en = 1'b1;
    @(negedge sclk);
    ref_en = 1'b0;
  endtask

  int guard;
  initial begin
    cycles(3);
    #2 s_rst_n = 1'b1;
    flag_init_end = 1'b1;

    // First tick after a full interval.
    cycles(1502);

    // Single refresh; stray grant during TRFC; init drops mid-sequence.
    grant();
    cycles(6);
    ref_en = 1'b1;
    @(negedge sclk);
    ref_en = 1'b0;
    flag_init_end = 1'b0;
    cycles(4);
    flag_init_end = 1'b1;
    cycles(40);

    // Grant with zero debt is ignored.
    grant();
    cycles(10);

    // Six postponed refreshes: urgent, burst of four, debt two left.
    cycles(6 * 1500);
    grant();
    cycles(60);

    // Saturate debt, then time the grant so the first AREF meets a tick.
    cycles(10 * 1500);
    guard = 0;
    @(negedge sclk);
    while (m_ticker != RI - 4 && guard < 2000) begin
      @(negedge sclk);
      guard++;
    end
    chk("align_timeout", 32'(guard < 2000), 32'd1);
    ref_en = 1'b1;
    @(negedge sclk);
    ref_en = 1'b0;
    cycles(60);
    grant();
    cycles(60);

    // Build debt, then reset during the TRFC after the second AREF.
    cycles(2 * 1500);
    grant();
    cycles(14);
    #2 s_rst_n = 1'b0;
    #1;
    chk("rst_aref_cmd", 32'(aref_cmd), 32'(NOP));
    chk("rst_flag_ref_end", 32'(flag_ref_end), 32'd0);
    chk("rst_ref_req", 32'(ref_req), 32'd0);
    chk("rst_ref_urgent", 32'(ref_urgent), 32'd0);
    chk("rst_ref_busy", 32'(ref_busy), 32'd0);
    cycles(3);
    #2 s_rst_n = 1'b1;
    cycles(200);

    // Random grants and init toggling.
    for (int i = 0; i < 3000; i++) begin
      @(negedge sclk);
      ref_en = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) flag_init_end = ~flag_init_end;
    end
    @(negedge sclk);
    ref_en = 1'b0;
    flag_init_end = 1'b1;
    cycles(60);
    chk("pending_events", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
